// File: rtl/warp_xwb_pkg.sv
// warp_xwb_pkg: shared widths, x0 index and writeback entry types
package warp_xwb_pkg;
    localparam int XLEN = 64;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_ent_t;

    typedef struct packed {
        logic wen;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0] data;
    } wport_t;
endpackage

// File: rtl/warp_xwb_fifo.sv
// warp_xwb_fifo: synchronous FIFO with occupancy count and combinational head
module warp_xwb_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q <= '0;
        end else begin
            if (i_push) wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            if (i_pop) rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(i_push) - CW'(i_pop);
        end
    end

    // A push into a full FIFO is only issued alongside a pop, so overwriting the head slot is safe
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wptr_q] <= i_data;
    end

    assign o_head = mem_q[rptr_q];
    assign o_count = cnt_q;
endmodule

// File: rtl/warp_xwb.sv
// warp_xwb: merges arith, logic and buffered divider results onto two register-file write ports
module warp_xwb
    import warp_xwb_pkg::*;
#(
    parameter int DIV_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_arith_valid,
    input  logic [XLEN-1:0]   i_arith_result,
    input  logic [REG_AW-1:0] i_arith_rd,
    input  logic              i_logic_valid,
    input  logic [XLEN-1:0]   i_logic_result,
    input  logic [REG_AW-1:0] i_logic_rd,
    input  logic              i_div_valid,
    input  logic [XLEN-1:0]   i_div_quotient,
    input  logic [XLEN-1:0]   i_div_remainder,
    input  logic [REG_AW-1:0] i_div_rd,
    input  logic              i_div_rem,
    output logic              o_div_ready,
    output logic              o_rd1_wen,
    output logic [REG_AW-1:0] o_rd1_addr,
    output logic [XLEN-1:0]   o_rd1_wdata,
    output logic              o_rd2_wen,
    output logic [REG_AW-1:0] o_rd2_addr,
    output logic [XLEN-1:0]   o_rd2_wdata,
    output logic              o_overflow
);
    localparam int CW = $clog2(DIV_DEPTH + 1);

    wb_ent_t head, div_ent, d_ent;
    wport_t p1_d, p1_q, p2_d, p2_q;
    logic [CW-1:0] count;
    logic a_v, l_raw, l_v, div_v, empty, d_ok, d_wr, pop, push_try, push, ovf_q;

    always_comb begin
        a_v = i_arith_valid && i_arith_rd != X0;
        l_raw = i_logic_valid && i_logic_rd != X0;
        l_v = l_raw && !(a_v && i_logic_rd == i_arith_rd);
        div_v = i_div_valid && i_div_rd != X0;
        div_ent = '{i_div_rd, i_div_rem ? i_div_remainder : i_div_quotient};
        empty = count == '0;
        d_ent = empty ? div_ent : head;
        // D stalls at the head rather than racing an A/L write to the same register
        d_ok = (!empty || div_v) && !(a_v && d_ent.rd == i_arith_rd) && !(l_raw && d_ent.rd == i_logic_rd);
        d_wr = d_ok && !(a_v && l_v);
        pop = d_wr && !empty;
        push_try = div_v && !(d_wr && empty);
        push = push_try && (count < CW'(DIV_DEPTH) || pop);
        p1_d = a_v ? '{1'b1, i_arith_rd, i_arith_result} : d_wr ? '{1'b1, d_ent.rd, d_ent.data} : '0;
        p2_d = l_v ? '{1'b1, i_logic_rd, i_logic_result} : (d_wr && a_v) ? '{1'b1, d_ent.rd, d_ent.data} : '0;
    end

    warp_xwb_fifo #(.DEPTH(DIV_DEPTH), .W($bits(wb_ent_t))) u_fifo (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_push(push),
        .i_pop(pop),
        .i_data(div_ent),
        .o_head(head),
        .o_count(count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p1_q <= '0;
            p2_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            p1_q <= p1_d;
            p2_q <= p2_d;
            ovf_q <= ovf_q | (push_try && !push);
        end
    end

    assign o_div_ready = count < CW'(DIV_DEPTH);
    assign o_rd1_wen = p1_q.wen;
    assign o_rd1_addr = p1_q.addr;
    assign o_rd1_wdata = p1_q.data;
    assign o_rd2_wen = p2_q.wen;
    assign o_rd2_addr = p2_q.addr;
    assign o_rd2_wdata = p2_q.data;
    assign o_overflow = ovf_q;
endmodule
